// File: rtl/data_memory_sized.sv
//==============================================================================
// Module      : data_memory_sized
// Description : RV64 data memory with byte/half/word/double sizing, sign/zero
//               extension on loads, byte-lane stores, a valid/ready request
//               port with fixed programmable latency, and misaligned /
//               out-of-range fault reporting. One request outstanding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_memory_sized #(
    parameter int XLEN        = 64,
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 64
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [XLEN-1:0]   Data_write,
    output logic              resp_valid,
    output logic [XLEN-1:0]   Data_read,
    output logic              misaligned,
    output logic              out_of_range
);

    localparam int              c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] c_LIMIT  = (ADDR_W+1)'(DEPTH_WORDS * 8);
    localparam logic [3:0]      c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

    logic [XLEN-1:0]   r_data;
    logic              r_mis;
    logic              r_oor;

    logic              w_accept;
    logic [3:0]        w_nbytes;
    logic [2:0]        w_lane;
    logic              w_mis;
    logic [ADDR_W:0]   w_end;
    logic              w_oor;
    logic              w_fault;
    logic [c_IDX_W-1:0] w_idx;
    logic [XLEN-1:0]   w_word;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_load;
    logic [7:0]        w_mask;
    logic [XLEN-1:0]   w_wdata;

    // Held in reset the port refuses requests so nothing can be committed.
    assign req_ready = (r_state == ST_IDLE) && Rst_n;
    assign w_accept  = req_valid && req_ready;

    assign w_nbytes  = 4'd1 << req_size;
    assign w_lane    = address[2:0];
    assign w_mis     = (w_lane & (w_nbytes[2:0] - 3'd1)) != 3'd0;
    // One extra bit so the last-byte computation cannot wrap to a low address.
    assign w_end     = {1'b0, address} + {{(ADDR_W-3){1'b0}}, w_nbytes};
    assign w_oor     = w_end > c_LIMIT;
    assign w_fault   = w_mis || w_oor;

    assign w_idx     = address[c_IDX_W+2:3];
    assign w_word    = r_mem[w_idx];
    assign w_shift   = w_word >> {w_lane, 3'b000};
    assign w_mask    = ((8'd1 << w_nbytes) - 8'd1) << w_lane;
    assign w_wdata   = Data_write << {w_lane, 3'b000};

    // Extract the addressed lanes and extend to full width.
    always_comb begin
        w_load = '0;
        case (req_size)
            2'b00: w_load = req_unsigned ? {{(XLEN-8){1'b0}}, w_shift[7:0]}
                                         : {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            2'b01: w_load = req_unsigned ? {{(XLEN-16){1'b0}}, w_shift[15:0]}
                                         : {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            2'b10: w_load = req_unsigned ? {{(XLEN-32){1'b0}}, w_shift[31:0]}
                                         : {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
            default: w_load = w_shift;
        endcase
    end

    // Store commit at the accept edge; faulting stores touch no lane.
    always_ff @(posedge Clk) begin
        if (w_accept && req_write && !w_fault) begin
            for (int i = 0; i < 8; i++) begin
                if (w_mask[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
        end
    end

    // State and latency counter register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> (WAIT x LATENCY-1) -> RESP -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                end
                w_cnt_nxt = r_cnt - 4'd1;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture load result and fault flags at the accept edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_data <= '0;
            r_mis  <= 1'b0;
            r_oor  <= 1'b0;
        end else if (w_accept) begin
            r_data <= (req_write || w_fault) ? '0 : w_load;
            r_mis  <= w_mis;
            r_oor  <= w_oor;
        end
    end

    assign resp_valid   = (r_state == ST_RESP);
    assign Data_read    = resp_valid ? r_data : '0;
    assign misaligned   = resp_valid && r_mis;
    assign out_of_range = resp_valid && r_oor;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none

module tb_data_memory_sized;

    localparam int LAT  = 2;
    localparam int LAT4 = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst4_n;
    logic        req_valid, req_valid4;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] address, data_write;

    logic        req_ready, resp_valid, mis, oor;
    logic [63:0] data_read;
    logic        req_ready4, resp_valid4, mis4, oor4;
    logic [63:0] data_read4;

    data_memory_sized #(.XLEN(64), .DEPTH_WORDS(32), .LATENCY(LAT), .ADDR_W(64)) dut (
        .Clk(clk), .Rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .Data_write(data_write), .resp_valid(resp_valid),
        .Data_read(data_read), .misaligned(mis), .out_of_range(oor)
    );

    data_memory_sized #(.XLEN(64), .DEPTH_WORDS(32), .LATENCY(LAT4), .ADDR_W(64)) dut4 (
        .Clk(clk), .Rst_n(rst4_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .Data_write(data_write), .resp_valid(resp_valid4),
        .Data_read(data_read4), .misaligned(mis4), .out_of_range(oor4)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic        mis;
        logic        oor;
        int          acc;
        string       tag;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor for the LATENCY=2 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_pending", {63'd0, req_ready}, {63'd0, sb.size() == 0});
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    // Edge that samples the response, relative to the accept edge.
                    chk({e.tag, "_latency"}, 64'(cyc + 1 - e.acc), 64'(LAT));
                    chk({e.tag, "_data"}, data_read, e.data);
                    chk({e.tag, "_mis"}, {63'd0, mis}, {63'd0, e.mis});
                    chk({e.tag, "_oor"}, {63'd0, oor}, {63'd0, e.oor});
                end
            end else begin
                chk("idle_data", data_read, 64'd0);
                chk("idle_flags", {62'd0, mis, oor}, 64'd0);
            end
        end
    end

    task automatic req(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] ed, input logic em, input logic eo,
                       input string tag, input logic hold, output int acc);
        exp_t e;
        acc = -1;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = uns;
        address = addr; data_write = wd; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        e.data = ed; e.mis = em; e.oor = eo; e.acc = acc; e.tag = tag;
        sb.push_back(e);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int a0, a1, a2;
        int seen, lat;
        rst_n = 1'b0; rst4_n = 1'b0;
        req_valid = 1'b0; req_valid4 = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        address = '0; data_write = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_data_read", data_read, 64'd0);
        chk("rst_flags", {62'd0, mis, oor}, 64'd0);
        chk("rst4_resp_valid", {63'd0, resp_valid4}, 64'd0);
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", {63'd0, req_ready}, 64'd1);

        // Double store and load round trip
        req(1, 2'b11, 0, 64'h10, 64'hABCD_1234_5678_90AB, 0, 0, 0, "sd_10", 0, a0);
        req(0, 2'b11, 0, 64'h10, 0, 64'hABCD_1234_5678_90AB, 0, 0, "ld_10", 0, a0);

        // Byte store into lane 3, byte loads signed/unsigned
        req(1, 2'b00, 0, 64'h13, 64'h1234_5678_9ABC_DEFF, 0, 0, 0, "sb_13", 0, a0);
        req(0, 2'b11, 0, 64'h10, 0, 64'hABCD_1234_FF78_90AB, 0, 0, "ld_10b", 0, a0);
        req(0, 2'b00, 0, 64'h13, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "lb_13", 0, a0);
        req(0, 2'b00, 1, 64'h13, 0, 64'h0000_0000_0000_00FF, 0, 0, "lbu_13", 0, a0);

        // Half / word loads
        req(0, 2'b01, 0, 64'h10, 0, 64'hFFFF_FFFF_FFFF_90AB, 0, 0, "lh_10", 0, a0);
        req(0, 2'b10, 1, 64'h14, 0, 64'h0000_0000_ABCD_1234, 0, 0, "lwu_14", 0, a0);
        req(0, 2'b10, 0, 64'h14, 0, 64'hFFFF_FFFF_ABCD_1234, 0, 0, "lw_14", 0, a0);
        req(0, 2'b01, 1, 64'h16, 0, 64'h0000_0000_0000_ABCD, 0, 0, "lhu_16", 0, a0);

        // Misaligned store is suppressed
        req(1, 2'b11, 0, 64'h20, 64'h0123_4567_89AB_CDEF, 0, 0, 0, "sd_20", 0, a0);
        req(1, 2'b01, 0, 64'h21, 64'h5555, 0, 1, 0, "sh_21_mis", 0, a0);
        req(0, 2'b11, 0, 64'h20, 0, 64'h0123_4567_89AB_CDEF, 0, 0, "ld_20", 0, a0);
        req(0, 2'b10, 0, 64'h22, 0, 0, 1, 0, "lw_22_mis", 0, a0);

        // Top-of-range accesses and out-of-range faults
        req(1, 2'b11, 0, 64'hF8, 64'h1111_2222_3333_4444, 0, 0, 0, "sd_f8", 0, a0);
        req(0, 2'b11, 0, 64'hF8, 0, 64'h1111_2222_3333_4444, 0, 0, "ld_f8", 0, a0);
        req(0, 2'b00, 0, 64'hFF, 0, 64'h0000_0000_0000_0011, 0, 0, "lb_ff", 0, a0);
        req(0, 2'b10, 0, 64'hFC, 0, 64'h0000_0000_1111_2222, 0, 0, "lw_fc", 0, a0);
        req(0, 2'b11, 0, 64'h100, 0, 0, 0, 1, "ld_100_oor", 0, a0);
        req(0, 2'b01, 0, 64'hFF, 0, 0, 1, 1, "lh_ff_both", 0, a0);
        req(0, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 1, "ld_wrap_oor", 0, a0);
        req(1, 2'b11, 0, 64'h0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, "sd_0", 0, a0);
        req(1, 2'b11, 0, 64'h100, 64'hBAD0_BAD0_BAD0_BAD0, 0, 0, 1, "sd_100_oor", 0, a0);
        req(0, 2'b11, 0, 64'h0, 0, 64'hDEAD_BEEF_0000_0001, 0, 0, "ld_0_noalias", 0, a0);

        // req_valid held continuously: one accept per LAT+1 cycles
        req(0, 2'b11, 0, 64'h10, 0, 64'hABCD_1234_FF78_90AB, 0, 0, "hold_a", 1, a0);
        req(0, 2'b11, 0, 64'h20, 0, 64'h0123_4567_89AB_CDEF, 0, 0, "hold_b", 1, a1);
        req(0, 2'b11, 0, 64'hF8, 0, 64'h1111_2222_3333_4444, 0, 0, "hold_c", 0, a2);
        chk("throughput_ab", 64'(a1 - a0), 64'(LAT + 1));
        chk("throughput_bc", 64'(a2 - a1), 64'(LAT + 1));
        drain();

        // LATENCY=4 instance: async reset during WAIT drops the response
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
        address = 64'h48; data_write = 64'hC0FF_EE00_1234_5678;
        req_valid4 = 1'b1;
        chk("l4_ready_before", {63'd0, req_ready4}, 64'd1);
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        @(negedge clk);
        #2 rst4_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid4) seen++;
            if (i == 2) rst4_n = 1'b1;
        end
        chk("l4_no_resp_after_reset", 64'(seen), 64'd0);
        chk("l4_ready_after_reset", {63'd0, req_ready4}, 64'd1);

        // Immediate load after reset; store committed before reset persists
        req_write = 1'b0; address = 64'h48; data_write = '0;
        req_valid4 = 1'b1;
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        a0 = cyc;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid4 && lat < 0) begin
                lat = cyc + 1 - a0;
                chk("l4_ld_data", data_read4, 64'hC0FF_EE00_1234_5678);
                chk("l4_ld_flags", {62'd0, mis4, oor4}, 64'd0);
            end
        end
        chk("l4_ld_latency", 64'(lat), 64'(LAT4));

        repeat (3) @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
